// File: rtl/debug_cmd_sync.sv
// debug_cmd_sync: system-clock side of the JTAG debug slave; synchronizes TCK-domain update strobes and queues decoded commands
module debug_cmd_sync #(
   parameter int IR_W         = 2,
   parameter int DATA_W       = 38,
   parameter int DEPTH        = 4,
   parameter int SYNC_STAGES  = 2,
   parameter int ACTION_BIT   = 37,
   parameter int FLUSH_ON_UIR = 1
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     vs_udr,
   input  logic                     vs_uir,
   input  logic [IR_W-1:0]          ir_in,
   input  logic [DATA_W-1:0]        sr,
   input  logic                     cmd_ready,
   input  logic                     overrun_clr,
   output logic [DATA_W-1:0]        jdo,
   output logic [IR_W-1:0]          cmd_ir,
   output logic [(1<<IR_W)-1:0]     take_action,
   output logic [(1<<IR_W)-1:0]     take_no_action,
   output logic                     ir_update,
   output logic [$clog2(DEPTH):0]   pending,
   output logic                     overrun
);
   localparam int LANES = 1 << IR_W;
   localparam int AW    = $clog2(DEPTH);
   localparam int EW    = IR_W + DATA_W;

   if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
      $error("DEPTH must be a power of two >= 2");
   end
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("SYNC_STAGES must be >= 2");
   end
   if (ACTION_BIT >= DATA_W) begin : g_bad_action
      $error("ACTION_BIT must be below DATA_W");
   end

   logic [SYNC_STAGES-1:0] udr_sync, uir_sync;
   logic                   udr_d, uir_d, udr_rise, uir_rise;
   logic [EW-1:0]          mem [DEPTH];
   logic [AW:0]            wr_ptr, rd_ptr;
   logic [AW-1:0]          wr_idx;
   logic [EW-1:0]          head;
   logic [IR_W-1:0]        head_ir;
   logic [DATA_W-1:0]      head_data;
   logic [LANES-1:0]       head_lane;
   logic                   flush, full, pop, push, drop;

   // two-flop (or deeper) synchronizers plus a level-history flop for edge detection
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         udr_sync <= '0;
         uir_sync <= '0;
         udr_d    <= 1'b0;
         uir_d    <= 1'b0;
      end else begin
         udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
         uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
         udr_d    <= udr_sync[SYNC_STAGES-1];
         uir_d    <= uir_sync[SYNC_STAGES-1];
      end

   assign udr_rise = udr_sync[SYNC_STAGES-1] & ~udr_d;
   assign uir_rise = uir_sync[SYNC_STAGES-1] & ~uir_d;

   // a flush restarts the queue from slot 0, so a coincident push lands there
   assign flush     = (FLUSH_ON_UIR != 0) && uir_rise;
   assign pending   = wr_ptr - rd_ptr;
   assign full      = pending == (AW+1)'(DEPTH);
   assign pop       = (pending != '0) && cmd_ready && !flush;
   assign push      = udr_rise && (!full || pop || flush);
   assign drop      = udr_rise && !push;
   assign wr_idx    = flush ? '0 : wr_ptr[AW-1:0];
   assign head      = mem[rd_ptr[AW-1:0]];
   assign head_ir   = head[EW-1:DATA_W];
   assign head_data = head[DATA_W-1:0];
   assign head_lane = LANES'(1) << head_ir;

   // queue pointers; extra MSB distinguishes full from empty
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         wr_ptr <= (flush ? '0 : wr_ptr) + (AW+1)'(push);
         rd_ptr <= flush ? '0 : rd_ptr + (AW+1)'(pop);
      end

   // command storage; the IR/data pair is captured unsynchronized since it is stable around the strobe
   always_ff @(posedge clk)
      if (push) mem[wr_idx] <= {ir_in, sr};

   // issue stage: latch the popped command and pulse its action lane for one cycle
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         jdo            <= '0;
         cmd_ir         <= '0;
         take_action    <= '0;
         take_no_action <= '0;
         ir_update      <= 1'b0;
         overrun        <= 1'b0;
      end else begin
         ir_update      <= uir_rise;
         overrun        <= drop | (overrun & ~overrun_clr);
         take_action    <= (pop && head_data[ACTION_BIT]) ? head_lane : '0;
         take_no_action <= (pop && !head_data[ACTION_BIT]) ? head_lane : '0;
         if (pop) begin
            jdo    <= head_data;
            cmd_ir <= head_ir;
         end
      end
endmodule

// File: tb/tb_debug_cmd_sync.sv
// tb_debug_cmd_sync: table-driven and scoreboard checks of debug_cmd_sync with and without IR flush
module tb_debug_cmd_sync;
   localparam int S = 2;

   typedef struct {
      logic [1:0]  ir;
      logic [37:0] data;
      logic [3:0]  ta;
      logic [3:0]  tna;
   } cmd_t;

   typedef struct {
      logic [1:0]  ir;
      logic [37:0] data;
      int          hold;
      logic [3:0]  ta;
      logic [3:0]  tna;
   } vec_t;

   logic        clk = 0, reset_n = 0, vs_udr = 0, vs_uir = 0, cmd_ready = 0, overrun_clr = 0;
   logic [1:0]  ir_in = 0;
   logic [37:0] sr = 0;
   logic [37:0] jdo, jdo2;
   logic [1:0]  cmd_ir, cmd_ir2;
   logic [3:0]  ta, tna, ta2, tna2;
   logic        ir_update, ir_update2, overrun, overrun2;
   logic [2:0]  pending, pending2;

   int   total = 0, bad = 0, pulses = 0, pulses2 = 0;
   bit   pulse_seen;
   cmd_t q[$], q2[$];
   vec_t vecs[4];

   always #5 clk = ~clk;

   debug_cmd_sync #(.FLUSH_ON_UIR(1)) dut (
      .clk(clk), .reset_n(reset_n), .vs_udr(vs_udr), .vs_uir(vs_uir), .ir_in(ir_in), .sr(sr),
      .cmd_ready(cmd_ready), .overrun_clr(overrun_clr), .jdo(jdo), .cmd_ir(cmd_ir),
      .take_action(ta), .take_no_action(tna), .ir_update(ir_update), .pending(pending), .overrun(overrun));

   debug_cmd_sync #(.FLUSH_ON_UIR(0)) dut_nf (
      .clk(clk), .reset_n(reset_n), .vs_udr(vs_udr), .vs_uir(vs_uir), .ir_in(ir_in), .sr(sr),
      .cmd_ready(cmd_ready), .overrun_clr(overrun_clr), .jdo(jdo2), .cmd_ir(cmd_ir2),
      .take_action(ta2), .take_no_action(tna2), .ir_update(ir_update2), .pending(pending2), .overrun(overrun2));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic cmd_t mk(input logic [1:0] ir, input logic [37:0] d);
      cmd_t c;
      c.ir   = ir;
      c.data = d;
      c.ta   = d[37] ? 4'(1) << ir : 4'd0;
      c.tna  = d[37] ? 4'd0 : 4'(1) << ir;
      return c;
   endfunction

   task automatic cmp_cmd(input string who, input cmd_t e, input logic [37:0] j, input logic [1:0] ci,
                          input logic [3:0] a, input logic [3:0] n);
      chk({who, "_jdo"}, j, e.data);
      chk({who, "_cmd_ir"}, ci, e.ir);
      chk({who, "_take_action"}, a, e.ta);
      chk({who, "_take_no_action"}, n, e.tna);
   endtask

   // advance to the next falling edge and score any issued command from either instance
   task automatic tick();
      cmd_t e;
      @(negedge clk);
      pulse_seen = 0;
      if (reset_n) begin
         if ((ta | tna) != '0) begin
            pulse_seen = 1;
            pulses++;
            chk("onehot", $countones(ta | tna), 1);
            chk("dut_expected_cmd_avail", q.size() != 0, 1);
            if (q.size() != 0) begin
               e = q.pop_front();
               cmp_cmd("dut", e, jdo, cmd_ir, ta, tna);
            end
         end
         if ((ta2 | tna2) != '0) begin
            pulses2++;
            chk("onehot_nf", $countones(ta2 | tna2), 1);
            chk("nf_expected_cmd_avail", q2.size() != 0, 1);
            if (q2.size() != 0) begin
               e = q2.pop_front();
               cmp_cmd("nf", e, jdo2, cmd_ir2, ta2, tna2);
            end
         end
      end
   endtask

   task automatic send(input logic [1:0] ir, input logic [37:0] d, input int hold, input bit keep);
      ir_in  = ir;
      sr     = d;
      vs_udr = 1;
      if (keep) begin
         q.push_back(mk(ir, d));
         q2.push_back(mk(ir, d));
      end
      repeat (hold) tick();
      vs_udr = 0;
      repeat (S + 1) tick();
   endtask

   initial begin
      int lat, p0, upd, upd2;
      vecs[0] = '{ir: 2'b01, data: 38'h20_0000_0ABC, hold: 10, ta: 4'b0010, tna: 4'b0000};
      vecs[1] = '{ir: 2'b11, data: 38'h00_1234_5678, hold: 50, ta: 4'b0000, tna: 4'b1000};
      vecs[2] = '{ir: 2'b00, data: 38'h3F_FFFF_FFFF, hold: 5,  ta: 4'b0001, tna: 4'b0000};
      vecs[3] = '{ir: 2'b10, data: 38'h1F_FFFF_FFFE, hold: 5,  ta: 4'b0000, tna: 4'b0100};

      repeat (3) tick();
      chk("rst_jdo", jdo, 0);
      chk("rst_cmd_ir", cmd_ir, 0);
      chk("rst_take_action", ta, 0);
      chk("rst_take_no_action", tna, 0);
      chk("rst_ir_update", ir_update, 0);
      chk("rst_pending", pending, 0);
      chk("rst_overrun", overrun, 0);
      reset_n   = 1;
      cmd_ready = 1;
      repeat (2) tick();

      // decode table: lane, polarity, latency and single event per held strobe
      for (int v = 0; v < 4; v++) begin
         cmd_t e;
         ir_in = vecs[v].ir;
         sr    = vecs[v].data;
         e = '{ir: vecs[v].ir, data: vecs[v].data, ta: vecs[v].ta, tna: vecs[v].tna};
         q.push_back(e);
         q2.push_back(e);
         vs_udr = 1;
         p0  = pulses;
         lat = 0;
         for (int i = 1; i <= vecs[v].hold + 6; i++) begin
            tick();
            if (pulse_seen && lat == 0) lat = i;
            if (i == vecs[v].hold) vs_udr = 0;
         end
         chk($sformatf("vec%0d_latency", v), lat, S + 2);
         chk($sformatf("vec%0d_pulse_count", v), pulses - p0, 1);
         chk($sformatf("vec%0d_pending", v), pending, 0);
      end
      chk("vec_jdo_hold", jdo, vecs[3].data);

      // overflow: fifth command dropped, then back-to-back drain
      cmd_ready = 0;
      for (int i = 1; i <= 5; i++) send(2'b00, 38'(i), S + 2, i <= 4);
      chk("ovf_pending", pending, 4);
      chk("ovf_overrun", overrun, 1);
      cmd_ready = 1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("drain_pulse%0d", i), pulse_seen, 1);
      end
      tick();
      chk("drain_pending", pending, 0);
      chk("overrun_sticky", overrun, 1);
      overrun_clr = 1;
      tick();
      overrun_clr = 0;
      tick();
      chk("overrun_cleared", overrun, 0);

      // full FIFO, push coincident with the first pop
      cmd_ready = 0;
      for (int i = 0; i < 4; i++) send(2'(i), {1'b1, 37'(16 + i)}, S + 2, 1);
      ir_in  = 2'b10;
      sr     = 38'h00_0000_0055;
      vs_udr = 1;
      q.push_back(mk(ir_in, sr));
      q2.push_back(mk(ir_in, sr));
      repeat (S) tick();
      cmd_ready = 1;
      tick();
      chk("full_pushpop_pending", pending, 4);
      chk("full_pushpop_overrun", overrun, 0);
      chk("full_pushpop_pending_nf", pending2, 4);
      repeat (3) tick();
      vs_udr = 0;
      repeat (8) tick();
      chk("full_pushpop_drained", q.size(), 0);
      chk("full_pushpop_pending_end", pending, 0);

      // Update-IR flush versus retain
      cmd_ready = 0;
      for (int i = 0; i < 3; i++) send(2'(i), {1'b0, 37'(32 + i)}, S + 2, 1);
      chk("pre_flush_pending", pending, 3);
      vs_uir = 1;
      upd = 0;
      upd2 = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         upd += int'(ir_update);
         upd2 += int'(ir_update2);
         if (i == 5) vs_uir = 0;
      end
      chk("ir_update_once", upd, 1);
      chk("ir_update_once_nf", upd2, 1);
      chk("flush_pending", pending, 0);
      chk("noflush_pending", pending2, 3);
      q.delete();
      p0 = pulses;
      cmd_ready = 1;
      repeat (8) tick();
      chk("flush_no_pulses", pulses - p0, 0);
      chk("noflush_all_issued", q2.size(), 0);

      // asynchronous reset mid-drain
      cmd_ready = 0;
      for (int i = 0; i < 4; i++) send(2'b01, {1'b1, 37'(48 + i)}, S + 2, 1);
      cmd_ready = 1;
      tick();
      chk("pre_reset_pending", pending, 3);
      #2 reset_n = 0;
      #1;
      chk("arst_jdo", jdo, 0);
      chk("arst_cmd_ir", cmd_ir, 0);
      chk("arst_take", {ta, tna}, 0);
      chk("arst_pending", pending, 0);
      chk("arst_overrun", overrun, 0);
      q.delete();
      q2.delete();
      repeat (3) tick();
      #2 reset_n = 1;
      p0 = pulses;
      repeat (8) tick();
      chk("post_reset_no_pulses", pulses - p0, 0);
      send(2'b11, 38'h21_2345_6789, S + 2, 1);
      repeat (3) tick();
      chk("post_reset_issued", q.size(), 0);
      chk("post_reset_pulse", pulses - p0, 1);
      chk("final_nf_empty", q2.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/debug_cmd_sync.md
Name: debug_cmd_sync

Overview:
- System-clock half of the next-generation JTAG debug slave.
- Receives asynchronous Update-DR/Update-IR strobes and the quasi-static shift-register contents from the TCK domain, synchronizes them, and queues the commands in a DEPTH-entry FIFO.
- Drains the queue under CPU-side flow control, presenting the command word on jdo with one-hot take_action/take_no_action pulses per IR code.
- Generalises the fixed 2-bit-IR/38-bit single-shot decode to parametrised widths, buffering, overrun detection and IR-change flush.

Parameters:
- IR_W, 2, instruction register width; number of action lanes = 2**IR_W.
- DATA_W, 38, shift register / jdo width.
- DEPTH, 4, command FIFO entries; power of two, >=2.
- SYNC_STAGES, 2, synchronizer flops per strobe; >=2.
- ACTION_BIT, 37, index into data selecting action (1) vs no-action (0); must be < DATA_W.
- FLUSH_ON_UIR, 1, 1 = Update-IR edge discards all queued commands.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- vs_udr  in  1  Update-DR strobe, TCK domain, asynchronous.
- vs_uir  in  1  Update-IR strobe, TCK domain, asynchronous.
- ir_in  in  IR_W  current virtual IR, quasi-static.
- sr  in  DATA_W  shift register contents, quasi-static.
- cmd_ready  in  1  consumer can accept a command this cycle.
- overrun_clr  in  1  clears sticky overrun.
- jdo  out  DATA_W  data of last issued command.
- cmd_ir  out  IR_W  IR of last issued command.
- take_action  out  2**IR_W  one-hot 1-cycle pulse, lane = IR, data[ACTION_BIT]=1.
- take_no_action  out  2**IR_W  one-hot 1-cycle pulse, lane = IR, data[ACTION_BIT]=0.
- ir_update  out  1  1-cycle pulse on synchronized Update-IR rising edge.
- pending  out  $clog2(DEPTH)+1  FIFO occupancy.
- overrun  out  1  sticky: a command was dropped because the FIFO was full.

Behaviour:
- Reset: all synchronizer flops, edge-detect flops and FIFO pointers 0. Outputs during and after reset: jdo=0, cmd_ir=0, take_action=0, take_no_action=0, ir_update=0, pending=0, overrun=0. Reset asserted mid-operation drops queued commands; no pulses are emitted until a new strobe arrives.
- Synchronizer: each strobe passes through SYNC_STAGES flops plus one edge-detect flop. udr_rise/uir_rise are high for exactly one cycle per rising edge of the synchronized level. A level held high produces one event only.
- Capture: on the udr_rise cycle, {ir_in, sr} are sampled directly without synchronization. The source guarantees they are stable from the vs_udr assertion until SYNC_STAGES+2 clk cycles afterwards; the bench honours this.
- Push: on the udr_rise cycle.
  - Not full: entry written; pending increments at the next edge.
  - Full and no pop in the same cycle: entry dropped, overrun <= 1.
  - Full with a simultaneous pop: push succeeds, pending unchanged.
- Pop: when pending!=0 and cmd_ready=1. At that edge:
  - jdo <= head data; cmd_ir <= head IR.
  - Exactly one of take_action[head IR] / take_no_action[head IR] pulses high for the following cycle.
  - jdo and cmd_ir hold until the next pop.
- Throughput: at most one pop per cycle.
- Latency, empty FIFO with cmd_ready=1: let edge k be the first clk edge sampling vs_udr=1. The pulse is high in the cycle after edge k+SYNC_STAGES+1, i.e. SYNC_STAGES+2 edges after edge k.
- cmd_ready=0: commands accumulate and no pulses are emitted.
- Update-IR: uir_rise registers ir_update high for one cycle.
  - FLUSH_ON_UIR=1: pointers reset and pending -> 0 at that edge; any pop requested in the same cycle is suppressed.
  - Simultaneous uir_rise and udr_rise: flush takes priority, then the new command is pushed; resulting pending = 1.
- overrun: set has priority over overrun_clr in the same cycle. It is cleared only by overrun_clr or reset.
- Pointers: DEPTH power of two, wrap naturally. pending = write count minus read count, range 0..DEPTH.
- Pulse exclusivity: take_action | take_no_action has at most one bit set in any cycle.

Test Plan:
1. Reset with all inputs 0, then pulse vs_udr high for 10 clk with ir_in=2'b01, sr=38'h20_0000_0ABC, cmd_ready=1 -> take_action=4'b0010 for exactly one cycle, SYNC_STAGES+2 edges after first sample; jdo=38'h20_0000_0ABC; cmd_ir=1; pending returns to 0.
2. sr[37]=0, ir_in=2'b11 -> take_no_action=4'b1000, take_action=0; vs_udr held high 50 cycles yields a single pulse.
3. cmd_ready=0, send 5 commands with sr=1..5 -> pending=4, overrun=1. Raise cmd_ready -> 4 pulses on consecutive cycles with jdo=1,2,3,4. Assert overrun_clr -> overrun=0.
4. FIFO full with cmd_ready=1 and a new udr_rise in the same cycle as a pop -> no overrun, pending stays 4, all 5 commands issued in order.
5. Queue 3 commands with cmd_ready=0, then pulse vs_uir -> ir_update pulses once, pending=0, no take_* pulses after cmd_ready=1. Repeat with FLUSH_ON_UIR=0 -> 3 commands issued.
6. Deassert reset_n asynchronously with pending=3 mid-drain -> all outputs 0 immediately. After release, no pulses until a fresh vs_udr edge; the next command issues normally.
